ahb_lite_byte_master: RTL
=========================

Name: ahb_lite_byte_master

Overview:
- Executes single-byte commands from the upstream arbiter/mux as AHB-Lite master transfers.
- Inputs are arbiter outputs: address, write data, write/read levels.
- Outputs drive one AHB-Lite bus (to the SRAM/peripheral interconnect) and return read data, error and wait-count to the requester.
- One transfer outstanding at a time; no bursts, no pipelining of back-to-back commands.

Parameters:
- HPROT_VAL, 4'b0011: constant HPROT driven on every transfer (non-cacheable data access).
- BIG_ENDIAN, 0: byte-lane mapping; 0 means lane = addr[1:0], 1 means lane = 3 - addr[1:0].

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- cmd_addr  in  32  byte address, sampled at accept.
- cmd_wdata  in  8  write byte, sampled at accept.
- cmd_write  in  1  write request level.
- cmd_read  in  1  read request level.
- cmd_ready  out  1  block can accept a command this cycle.
- rsp_valid  out  1  one-cycle pulse: transfer complete.
- rsp_rdata  out  8  read byte; valid with rsp_valid on reads, held until the next completion.
- rsp_err  out  1  HRESP was ERROR at completion; valid with rsp_valid.
- rsp_wait  out  8  HREADY-low cycles seen during the transfer, saturating at 255; valid with rsp_valid.
- HADDR  out  32  AHB address.
- HTRANS  out  2  AHB transfer type: IDLE=00, NONSEQ=10 only.
- HWRITE  out  1  AHB direction.
- HSIZE  out  3  constant 000 (byte).
- HBURST  out  3  constant 000 (SINGLE).
- HPROT  out  4  constant HPROT_VAL.
- HWDATA  out  32  write data.
- HRDATA  in  32  read data.
- HREADY  in  1  transfer ready.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (resetn low at a clk edge):
  - State goes to IDLE.
  - HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_wait=0.
  - cmd_ready=1 from the first cycle after reset.
  - Reset mid-transfer abandons the transfer without a response. Slave-side recovery is a system-level reset concern.
- Accept condition: cmd_ready && (cmd_write || cmd_read).
  - cmd_addr, cmd_wdata and direction are latched at accept.
  - If cmd_write and cmd_read are both high, the transfer is a write and the read is ignored.
- State IDLE:
  - cmd_ready=1, HTRANS=00.
  - On accept, go to ADDR. Accept-to-address-phase latency is 1 cycle.
- State ADDR:
  - HTRANS=10, HADDR=latched address, HWRITE=latched direction. Outputs are registered.
  - HREADY=1 at the edge: go to DATA.
  - HREADY=0: stay in ADDR, hold all outputs, increment the wait counter.
- State DATA:
  - HTRANS=00.
  - Writes drive HWDATA = {4{wdata}}, so every lane carries the byte. HWDATA is held stable for the whole data phase.
  - Each HREADY=0 cycle increments the wait counter, saturating at 255. No wrap.
  - HREADY=1 at the edge completes the transfer:
    - rsp_valid=1 for exactly one cycle.
    - rsp_err = HRESP.
    - Reads: rsp_rdata = HRDATA byte of the mapped lane. Writes leave rsp_rdata unchanged.
    - Go to REARM.
  - HRESP=1 with HREADY=0 (first cycle of an ERROR response): no action; wait for the second cycle.
- State REARM:
  - cmd_ready=0.
  - Move to IDLE on the first edge where cmd_write=0 and cmd_read=0.
  - Purpose: a level-held request from the registered arbiter is never re-executed. The requester must drop its request after rsp_valid.
- Wait counter clears at each accept.
- Minimum zero-wait transfer: accept edge, then 1 ADDR cycle, then 1 DATA cycle. rsp_valid is seen 2 cycles after accept.
- Commands arriving while not in IDLE are neither queued nor stored.

Test Plan:
- Zero-wait write, cmd_addr=0x0000_1002, cmd_wdata=0xA5 -> HTRANS=10 with HADDR=0x1002 for 1 cycle; next cycle HWDATA=0xA5A5A5A5; rsp_valid 2 cycles after accept with rsp_err=0, rsp_wait=0.
- Read 0x0000_2003, HRDATA=0x11223344, zero wait -> rsp_rdata=0x11 (BIG_ENDIAN=0); with BIG_ENDIAN=1 -> rsp_rdata=0x44.
- Read with HREADY low 2 cycles in ADDR and 3 in DATA -> HADDR/HTRANS held through ADDR; rsp_wait=5 at completion.
- Write with a two-cycle ERROR response (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) -> one rsp_valid pulse with rsp_err=1; next command accepted after the request drops.
- cmd_read held high 4 cycles past rsp_valid -> exactly one AHB transfer; cmd_ready returns 1 one cycle after cmd_read falls.
- Wait saturation: HREADY low 300 cycles -> rsp_wait=255. Separately, assert resetn low mid-DATA -> HTRANS=00, no rsp_valid, cmd_ready=1 after reset.

Source files
------------

// File: rtl/ahb_lite_byte_master.sv
// ahb_lite_byte_master
//
// Turns single-byte read/write commands from an upstream arbiter into
// single AHB-Lite transfers (NONSEQ, SINGLE, byte size). Only one transfer
// is in flight at a time; commands that arrive while busy are ignored.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   cmd_addr, cmd_wdata    command byte address and write byte (sampled at accept)
//   cmd_write, cmd_read    request levels; write wins when both are high
//   cmd_ready              high when a command can be accepted this cycle
//   rsp_valid              one-cycle completion pulse
//   rsp_rdata              read byte from the addressed lane, held between reads
//   rsp_err                HRESP at completion
//   rsp_wait               HREADY-low cycles during the transfer, saturating at 255
//   HADDR..HWDATA          AHB-Lite master outputs
//   HRDATA, HREADY, HRESP  AHB-Lite slave responses
//
// Parameters:
//   HPROT_VAL              constant protection attribute for every transfer
//   BIG_ENDIAN             0: lane = addr[1:0], 1: lane = 3 - addr[1:0]

module ahb_lite_byte_master #(
  parameter logic [3:0] HPROT_VAL  = 4'b0011,
  parameter bit         BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  input  logic        cmd_write,
  input  logic        cmd_read,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  rsp_wait,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    REARM
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] addr_q;
  logic [7:0]  wdata_q;
  logic        write_q;
  logic [7:0]  wait_cnt;
  logic        accept;
  logic [1:0]  lane;
  logic [7:0]  rdata_byte;

  assign accept = cmd_ready && (cmd_write || cmd_read);

  // Byte lane of the latched address; for two bits, 3 - x equals ~x.
  assign lane       = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
  assign rdata_byte = HRDATA[{lane, 3'b000} +: 8];

  assign HADDR  = addr_q;
  assign HWRITE = write_q;
  assign HWDATA = {4{wdata_q}};
  assign HSIZE  = 3'b000;
  assign HBURST = 3'b000;
  assign HPROT  = HPROT_VAL;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // HTRANS and cmd_ready decode straight from the state register, so they
  // change only on clock edges. REARM waits for the request level to drop so
  // a held request is not executed a second time.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    HTRANS     = 2'b00;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_write || cmd_read) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        HTRANS = 2'b10;
        if (HREADY) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (HREADY) begin
          state_next = REARM;
        end
      end
      REARM: begin
        if (!cmd_write && !cmd_read) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command latch, wait counter and response registers. An HREADY-low cycle
  // in DATA with HRESP high is the first half of an ERROR response and is
  // counted like any other wait; only the HREADY-high edge completes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q    <= 32'h0;
      wdata_q   <= 8'h00;
      write_q   <= 1'b0;
      wait_cnt  <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
      rsp_wait  <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        addr_q   <= cmd_addr;
        wdata_q  <= cmd_wdata;
        write_q  <= cmd_write;
        wait_cnt <= 8'h00;
      end else if ((state == ADDR || state == DATA) && !HREADY && wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (state == DATA && HREADY) begin
        rsp_valid <= 1'b1;
        rsp_err   <= HRESP;
        rsp_wait  <= wait_cnt;
        if (!write_q) begin
          rsp_rdata <= rdata_byte;
        end
      end
    end
  end

endmodule
